// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one countdown timer among NUM_REQ requesters.
// A round-robin pick is made only from IDLE. The winner's cycle count is
// captured at that moment and counted down while enable_i is high. The
// winner gets a one-cycle done_o pulse when the count runs out. The owner
// dropping its request aborts the countdown without a pulse.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_i        per-requester request, held until its done_o
//   cycles_i     per-requester count, slice k = cycles_i[k*WIDTH +: WIDTH]
//   enable_i     global count enable (low pauses the countdown)
//   gnt_o        one-hot owner of the timer (zero in IDLE)
//   done_o       one-hot, one-cycle completion pulse
//   busy_o       high whenever not IDLE
//   remaining_o  current countdown value
//
// state  | meaning
// IDLE   | timer free, round-robin pick on any request
// COUNT  | owner's countdown running (paused while enable_i low)
// DONE   | completion cycle, done_o to owner, back to IDLE

`ifndef kCYCLE_COUNTER_WIDTH
`define kCYCLE_COUNTER_WIDTH 32
`endif

module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = `kCYCLE_COUNTER_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] cycles_i,
  input  logic                     enable_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [WIDTH-1:0]         remaining_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_nxt;
  logic [IDX_W-1:0]   r_last_owner;
  logic [IDX_W-1:0]   w_last_nxt;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [WIDTH-1:0]   w_cycles [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_cycles[g] = cycles_i[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last owner, wrapping around;
  // the first requester found wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (!w_found && req_i[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_found) begin
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_cnt_nxt   = w_cycles[w_winner];
          w_state_nxt = (w_cycles[w_winner] == '0) ? S_DONE : S_COUNT;
        end
      end
      S_COUNT: begin
        // Abort is checked first so it wins over a same-cycle completion.
        if (!req_i[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (enable_i && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
          if (r_cnt == WIDTH'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_owner_oh  = NUM_REQ'(1) << r_owner;
  assign gnt_o       = (r_state == S_IDLE) ? '0 : w_owner_oh;
  assign done_o      = (r_state == S_DONE) ? w_owner_oh : '0;
  assign busy_o      = (r_state != S_IDLE);
  assign remaining_o = r_cnt;

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  cyc_in [4];
  logic [127:0] cycles_vec;
  logic         enable;
  logic [3:0]   gnt_o;
  logic [3:0]   done_o;
  logic         busy_o;
  logic [31:0]  remaining_o;

  assign cycles_vec = {cyc_in[3], cyc_in[2], cyc_in[1], cyc_in[0]};

  timer_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .cycles_i   (cycles_vec),
    .enable_i   (enable),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .remaining_o(remaining_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_now = 0;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Expected done_o pulses: which requester and in which cycle.
  typedef struct {
    logic [3:0] mask;
    int         cyc;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  typedef struct {
    int         who;
    int         n;
    logic [3:0] gnt;
    int         len;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now);
    end
  endtask

  task automatic push(input logic [3:0] mask, input int c);
    sb_t e;
    e.mask = mask;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc_now) begin
      n_chk++;
      n_err++;
      $display("FAIL done_missing: no pulse for %0h by cycle %0d", sb_q[0].mask, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    if (done_o != 4'b0) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got %0h at cycle %0d expected none", done_o, cyc_now);
      end else begin
        mon_e = sb_q.pop_front();
        if (done_o !== mon_e.mask || cyc_now != mon_e.cyc) begin
          n_err++;
          $display("FAIL done_pulse: got %0h at cycle %0d expected %0h at cycle %0d",
                   done_o, cyc_now, mon_e.mask, mon_e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_gnt"}, 32'(gnt_o), 32'h0);
    chk({name, "_done"}, 32'(done_o), 32'h0);
    chk({name, "_busy"}, 32'(busy_o), 32'h0);
    chk({name, "_rem"}, remaining_o, 32'h0);
  endtask

  // Wait for the done_o of the given requester, dropping its request then.
  task automatic wait_done(input string name, input logic [3:0] mask, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((done_o & mask) != 4'b0) begin
        seen = 1'b1;
        req  = req & ~mask;
      end
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'(seen), 32'h1);
      req = req & ~mask;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int glen = 0;
    cyc_in[v.who] = 32'(v.n);
    req = 4'b0001 << v.who;
    push(v.gnt, cyc_now + v.n + 1);
    for (int k = 0; k < v.n + 3; k++) begin
      @(negedge clk);
      if (k == 0) chk("vec_load_rem", remaining_o, 32'(v.n));
      if (gnt_o != 4'b0) begin
        glen++;
        chk("vec_gnt", 32'(gnt_o), 32'(v.gnt));
      end
      if (done_o != 4'b0) req = 4'b0;
    end
    chk("vec_gnt_len", 32'(glen), 32'(v.len));
    chk("vec_idle_busy", 32'(busy_o), 32'h0);
    req = 4'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int ndone;
    bit hit;
    vecs[0] = '{who: 0, n: 5, gnt: 4'b0001, len: 6};
    vecs[1] = '{who: 1, n: 1, gnt: 4'b0010, len: 2};
    vecs[2] = '{who: 2, n: 0, gnt: 4'b0100, len: 1};
    vecs[3] = '{who: 3, n: 3, gnt: 4'b1000, len: 4};
    vecs[4] = '{who: 0, n: 0, gnt: 4'b0001, len: 1};
    vecs[5] = '{who: 2, n: 7, gnt: 4'b0100, len: 8};

    rst = 1'b1;
    req = 4'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc_in[i] = 32'd0;
    idle(2);
    chk_zero("por");
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      idle(1);
    end

    // Fairness from a fresh reset: order 0,1,2,3,0, one IDLE cycle each.
    do_reset();
    for (int i = 0; i < 4; i++) cyc_in[i] = 32'd2;
    req = 4'b1111;
    c0 = cyc_now;
    push(4'b0001, c0 + 3);
    push(4'b0010, c0 + 7);
    push(4'b0100, c0 + 11);
    push(4'b1000, c0 + 15);
    push(4'b0001, c0 + 19);
    ndone = 0;
    hit = 1'b0;
    for (int i = 0; i < 30 && ndone < 5; i++) begin
      @(negedge clk);
      if (hit) begin
        chk("rr_idle_busy", 32'(busy_o), 32'h0);
        chk("rr_idle_gnt", 32'(gnt_o), 32'h0);
        hit = 1'b0;
      end
      if (done_o != 4'b0) begin
        ndone++;
        hit = 1'b1;
        if (ndone == 5) req = 4'b0;
      end
    end
    chk("rr_count", 32'(ndone), 32'd5);
    idle(2);

    // Pause: three disabled cycles delay completion by exactly three.
    cyc_in[1] = 32'd4;
    req = 4'b0010;
    push(4'b0010, cyc_now + 8);
    @(negedge clk);
    chk("pause_rem4", remaining_o, 32'd4);
    @(negedge clk);
    chk("pause_rem3", remaining_o, 32'd3);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_hold", remaining_o, 32'd3);
    end
    enable = 1'b1;
    wait_done("pause", 4'b0010, 10);
    idle(2);

    // Abort at remaining 6: back to IDLE next cycle, no done pulse.
    cyc_in[3] = 32'd10;
    req = 4'b1000;
    c0 = cyc_now;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (remaining_o == 32'd6) hit = 1'b1;
    end
    chk("abort_at6_cycle", 32'(cyc_now - c0), 32'd5);
    req = 4'b0;
    @(negedge clk);
    chk_zero("abort");
    idle(3);

    // Abort and completion in the same cycle: abort wins.
    cyc_in[0] = 32'd1;
    req = 4'b0001;
    @(negedge clk);
    chk("abortpri_rem", remaining_o, 32'd1);
    req = 4'b0;
    @(negedge clk);
    chk_zero("abortpri");
    idle(3);

    // Reset mid-count, then requester 0 must win despite owner 2 before.
    cyc_in[2] = 32'd10;
    req = 4'b0100;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (remaining_o == 32'd7) hit = 1'b1;
    end
    chk("rstmid_reach7", 32'(hit), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rstmid");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc_in[i] = 32'd1;
    req = 4'b1111;
    push(4'b0001, cyc_now + 2);
    @(negedge clk);
    chk("rstmid_first_gnt", 32'(gnt_o), 32'h1);
    @(negedge clk);
    req = 4'b0;
    idle(3);

    // cycles_i change during COUNT must not affect the countdown.
    cyc_in[0] = 32'd5;
    req = 4'b0001;
    push(4'b0001, cyc_now + 6);
    idle(2);
    cyc_in[0] = 32'd100;
    @(negedge clk);
    chk("stable_rem", remaining_o, 32'd3);
    wait_done("stable", 4'b0001, 10);
    idle(3);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d expected finish", cyc_now);
    $fatal(1, "watchdog expired");
  end

endmodule
